// File: rtl/sramlike_mem_ctrl_pkg.sv
// Shared encodings and helpers for the data-side (and later instruction-side)
// sram-like memory access controllers.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_DRAIN
  } state_e;

  // dword_ok is 0 on a 32-bit bus, where size 2'b11 has no meaning.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] addr_lo,
                                         input logic       dword_ok);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo[1:0];
      default: bad = !dword_ok || (|addr_lo);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sramlike_mem_ctrl_if.sv
// sram-like data bus between the MEM-stage controller (master) and memory (slave).
interface sramlike_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_addr_ok;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );

endinterface

// File: rtl/sramlike_mem_ctrl_load_formatter.sv
// Lane extraction for loads: shift the addressed bytes down, keep the access
// size, then sign- or zero-extend to the full bus width.
module load_formatter
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]          rdata,
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  logic [1:0]                 size,
  input  logic                       sign_ext,
  output logic [DATA_W-1:0]          data_out
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;
  logic              fill;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SZ_BYTE: begin
        keep_mask = DATA_W'(8'hFF);
        fill      = sign_ext & shifted[7];
      end
      SZ_HALF: begin
        keep_mask = DATA_W'(16'hFFFF);
        fill      = sign_ext & shifted[15];
      end
      SZ_WORD: begin
        keep_mask = DATA_W'(32'hFFFF_FFFF);
        fill      = sign_ext & shifted[31];
      end
      default: begin
        keep_mask = '1;
        fill      = 1'b0;
      end
    endcase
    data_out = (shifted & keep_mask) | (~keep_mask & {DATA_W{fill}});
  end

endmodule

// File: rtl/sramlike_mem_ctrl.sv
// MEM-stage data-side controller: turns a pipeline load/store into an
// sram-like req/addr_ok/data_ok transaction and produces the pipeline stall.
module sramlike_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              stall_out,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              addr_err,
  sramlike_mem_ctrl_if.master bus
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic              sign;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  req_t              cur_req;
  logic [DATA_W-1:0] wdata_lanes;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] capture;
  logic              misaligned;
  logic              issue;
  logic              bus_active;

  assign misaligned = ALIGN_CHECK && is_misaligned(req_size, req_addr[2:0], DATA_W == 64);
  assign addr_err   = req_valid && misaligned && (state_q == ST_IDLE);
  assign issue      = (state_q == ST_IDLE) && req_valid && !misaligned && !flush;

  always_comb begin
    wdata_lanes = req_wdata;
    case (req_size)
      SZ_BYTE: wdata_lanes = {(DATA_W/8){req_wdata[7:0]}};
      SZ_HALF: wdata_lanes = {(DATA_W/16){req_wdata[15:0]}};
      SZ_WORD: wdata_lanes = {(DATA_W/32){req_wdata[31:0]}};
      default: ;
    endcase
  end

  // In the issue cycle nothing is latched yet, so the bus is fed from the live request.
  always_comb begin
    if (issue) begin
      cur_req = '{wr: req_wr, size: req_size, sign: req_signed,
                  addr: req_addr, wdata: wdata_lanes};
    end else begin
      cur_req = req_q;
    end
  end

  assign bus_active     = issue || (state_q != ST_IDLE);
  assign bus.data_req   = issue || (state_q == ST_ADDR);
  assign bus.data_wr    = bus_active ? cur_req.wr    : 1'b0;
  assign bus.data_size  = bus_active ? cur_req.size  : 2'b00;
  assign bus.data_addr  = bus_active ? cur_req.addr  : '0;
  assign bus.data_wdata = bus_active ? cur_req.wdata : '0;

  load_formatter #(.DATA_W(DATA_W)) u_load_formatter (
    .rdata    (bus.data_rdata),
    .offset   (cur_req.addr[OFF_W-1:0]),
    .size     (cur_req.size),
    .sign_ext (cur_req.sign),
    .data_out (load_data)
  );

  assign capture = cur_req.wr ? '0 : load_data;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    stall_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          req_d     = cur_req;
          stall_out = 1'b1;
          if (bus.data_addr_ok && bus.data_data_ok) begin
            state_d = ST_DONE;
            rdata_d = capture;
          end else if (bus.data_addr_ok) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        stall_out = 1'b1;
        if (bus.data_addr_ok) begin
          // A response in the accept cycle completes the access; a flush then just drops it.
          if (bus.data_data_ok) begin
            state_d = flush ? ST_IDLE : ST_DONE;
            rdata_d = capture;
          end else begin
            state_d = flush ? ST_DRAIN : ST_DATA;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        stall_out = 1'b1;
        if (bus.data_data_ok) begin
          state_d = flush ? ST_IDLE : ST_DONE;
          rdata_d = capture;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        stall_out = req_valid;
        if (bus.data_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
